// File: rtl/mna_resp_flit_parser.sv
// mna_resp_flit_parser: turns NoC response flits (header + tail) into a single
// AXI4-Lite R or B beat. One response is in flight at a time; the flit
// interface is back-pressured while the R/B beat waits for its handshake.
//
// Optional feature: define MNA_RESP_PROTO_ERR_CNT_EN to add the saturating
// protocol-error counter output err_cnt.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a header flit; tails and invalid flits dropped
// WAIT_TAIL | header latched, waiting for a tail on the same VC
// RESP_R    | read data presented on R channel, waiting for rready
// RESP_B    | write response presented on B channel, waiting for bready

module mna_resp_flit_parser #(
    parameter int FLIT_W = 37,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid,
    output logic              flit_ready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic [3:0]        src_addr,
    output logic [2:0]        vc_id
`ifdef MNA_RESP_PROTO_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TAIL = 2'd1,
        RESP_R    = 2'd2,
        RESP_B    = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_HDR  = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b01;

    state_t            state_q, state_d;
    logic              rdy_en_q, rdy_en_d;
    logic              rd_flag_q, rd_flag_d;
    logic [3:0]        src_q, src_d;
    logic [2:0]        vc_q, vc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        bresp_q, bresp_d;

    logic [1:0]        f_type;
    logic [2:0]        f_vc;
    logic [31:0]       f_payload;
    logic              accept;

    // Field extraction and handshake qualification for the incoming flit.
    always_comb begin
        f_type    = flit_in[36:35];
        f_vc      = flit_in[34:32];
        f_payload = flit_in[31:0];
        // rdy_en_q keeps flit_ready low through reset and the first edge after it
        flit_ready = rdy_en_q && ((state_q == IDLE) || (state_q == WAIT_TAIL));
        accept     = flit_valid && flit_ready;
    end

    // Next-state and latch-enable logic for the response FSM.
    always_comb begin
        state_d   = state_q;
        rdy_en_d  = 1'b1;
        rd_flag_d = rd_flag_q;
        src_d     = src_q;
        vc_d      = vc_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (f_type == TYPE_HDR)) begin
                    rd_flag_d = flit_in[0];
                    src_d     = flit_in[31:28];
                    vc_d      = f_vc;
                    state_d   = WAIT_TAIL;
                end
            end
            WAIT_TAIL: begin
                if (accept) begin
                    if (f_type == TYPE_HDR) begin
                        // a fresh header supersedes the one still waiting for its tail
                        rd_flag_d = flit_in[0];
                        src_d     = flit_in[31:28];
                        vc_d      = f_vc;
                    end else if ((f_type == TYPE_TAIL) && (f_vc == vc_q)) begin
                        if (rd_flag_q) begin
                            rdata_d = DATA_W'(f_payload);
                            state_d = RESP_R;
                        end else begin
                            bresp_d = f_payload[1:0];
                            state_d = RESP_B;
                        end
                    end
                end
            end
            RESP_R: begin
                if (rready) state_d = IDLE;
            end
            RESP_B: begin
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_en_q  <= 1'b0;
            rd_flag_q <= 1'b0;
            src_q     <= '0;
            vc_q      <= '0;
            rdata_q   <= '0;
            bresp_q   <= '0;
        end else begin
            state_q   <= state_d;
            rdy_en_q  <= rdy_en_d;
            rd_flag_q <= rd_flag_d;
            src_q     <= src_d;
            vc_q      <= vc_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
        end
    end

    // Output drive straight from state and registered fields.
    always_comb begin
        rvalid   = (state_q == RESP_R);
        bvalid   = (state_q == RESP_B);
        rdata    = rdata_q;
        rresp    = 2'b00;
        bresp    = bresp_q;
        src_addr = src_q;
        vc_id    = vc_q;
    end

`ifdef MNA_RESP_PROTO_ERR_CNT_EN
    logic       err_hit;
    logic [7:0] err_cnt_q, err_cnt_d;

    // An accepted flit is an error unless it is a header in IDLE or a matching tail in WAIT_TAIL.
    always_comb begin
        err_hit = accept &&
                  !(((state_q == IDLE) && (f_type == TYPE_HDR)) ||
                    ((state_q == WAIT_TAIL) && (f_type == TYPE_TAIL) && (f_vc == vc_q)));
        err_cnt_d = err_cnt_q;
        if (err_hit && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Saturating error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
